// File: rtl/ifu_fetch_param.sv
// Parametrised instruction fetch unit: boots at RESET_PC, then fetches each next PC from WBU
// over a single-outstanding request/response port and hands the 32-bit lane to IDU.
module ifu_fetch_param #(
  parameter int              XLEN        = 64,
  parameter int              ADDR_W      = 32,
  parameter int              MEM_DW      = 64,
  parameter logic [XLEN-1:0] RESET_PC    = 'h80000000,
  parameter int              START_DELAY = 10
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ioWBU_ready,
  input  logic              ioWBU_valid,
  input  logic [XLEN-1:0]   ioWBU_npc,
  input  logic              ioIFU_ready,
  output logic              ioIFU_valid,
  output logic [31:0]       ioIFU_inst,
  output logic [XLEN-1:0]   ioIFU_pc,
  output logic [XLEN-1:0]   ioIFU_pc4,
  output logic [1:0]        ioIFU_fault,
  output logic              ioMem_reqValid,
  input  logic              ioMem_reqReady,
  output logic [ADDR_W-1:0] ioMem_addr,
  input  logic              ioMem_respValid,
  input  logic [MEM_DW-1:0] ioMem_rData,
  input  logic              ioMem_respErr,
  output logic [2:0]        dbg_state
);

  localparam int NLANES = MEM_DW / 32;
  localparam int OFF_W  = $clog2(MEM_DW / 8);
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int CNT_W  = 32;
  localparam logic [CNT_W-1:0] DELAY = CNT_W'(START_DELAY);

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_MIS  = 2'b01;
  localparam logic [1:0] FAULT_ACC  = 2'b10;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    IDLE = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  boot_cnt;
  logic [LANE_W-1:0] lane_idx;
  logic [31:0]       lane_data;
  logic              npc_misaligned;

  // Memory address is the fetch PC truncated to ADDR_W and aligned to one data beat.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [XLEN-1:0] p);
    logic [ADDR_W-1:0] a;
    a = p[ADDR_W-1:0];
    a[OFF_W-1:0] = '0;
    return a;
  endfunction

  generate
    if (NLANES > 1) begin : g_multi_lane
      assign lane_idx = ioIFU_pc[OFF_W-1:2];
    end else begin : g_single_lane
      assign lane_idx = '0;
    end
  endgenerate

  always_comb begin
    lane_data = ioMem_rData[31:0];
    for (int i = 0; i < NLANES; i++) begin
      if (lane_idx == LANE_W'(i)) lane_data = ioMem_rData[i*32 +: 32];
    end
  end

  assign npc_misaligned = (ioWBU_npc[1:0] != 2'b00);
  assign ioWBU_ready    = (state == IDLE);
  assign dbg_state      = state;

  // Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1;
  // the producer keeps valid and its payload stable until that edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= BOOT;
      boot_cnt       <= '0;
      ioIFU_valid    <= 1'b0;
      ioIFU_inst     <= '0;
      ioIFU_fault    <= FAULT_NONE;
      ioIFU_pc       <= RESET_PC;
      ioIFU_pc4      <= '0;
      ioMem_reqValid <= 1'b0;
      ioMem_addr     <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_cnt != '1) boot_cnt <= boot_cnt + CNT_W'(1);
          if (boot_cnt == DELAY) begin
            ioIFU_pc       <= RESET_PC;
            ioIFU_pc4      <= RESET_PC + XLEN'(4);
            ioMem_reqValid <= 1'b1;
            ioMem_addr     <= beat_addr(RESET_PC);
            state          <= REQ;
          end
        end
        IDLE: begin
          if (ioWBU_valid) begin
            ioIFU_pc  <= ioWBU_npc;
            ioIFU_pc4 <= ioWBU_npc + XLEN'(4);
            // A misaligned PC never reaches memory; it is reported straight away.
            if (npc_misaligned) begin
              ioIFU_fault <= FAULT_MIS;
              ioIFU_inst  <= '0;
              ioIFU_valid <= 1'b1;
              state       <= HOLD;
            end else begin
              ioMem_reqValid <= 1'b1;
              ioMem_addr     <= beat_addr(ioWBU_npc);
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (ioMem_reqReady) begin
            ioMem_reqValid <= 1'b0;
            ioMem_addr     <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (ioMem_respValid) begin
            if (ioMem_respErr) begin
              ioIFU_inst  <= '0;
              ioIFU_fault <= FAULT_ACC;
            end else begin
              ioIFU_inst  <= lane_data;
              ioIFU_fault <= FAULT_NONE;
            end
            ioIFU_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (ioIFU_ready) begin
            ioIFU_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
